// File: rtl/defines.sv
// Shared constants and types for the smiley collision detector.
//   SMILEY_SIZE_DEFAULT / EDGE_MARGIN_DEFAULT : default sprite geometry.
//   EDGE_* : bit positions inside the 4-bit {L,T,R,B} edge code.
//   COLLISION_OBJ : object index, which is also the emission order.
//   emit_state_e : emission FSM states.
package defines;

  localparam int unsigned SMILEY_SIZE_DEFAULT = 32;
  localparam int unsigned EDGE_MARGIN_DEFAULT = 8;

  localparam int unsigned EDGE_LEFT   = 3;
  localparam int unsigned EDGE_TOP    = 2;
  localparam int unsigned EDGE_RIGHT  = 1;
  localparam int unsigned EDGE_BOTTOM = 0;

  localparam int NUM_OBJ = 5;

  typedef enum logic [2:0] {
    FRAME    = 3'd0,
    OBSTACLE = 3'd1,
    SPRING   = 3'd2,
    FLIPPER  = 3'd3,
    BUMPER   = 3'd4
  } COLLISION_OBJ;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StEmit = 1'b1
  } emit_state_e;

endpackage

// File: rtl/smiley_edge_classifier.sv
// Combinational edge classifier: maps the current scan pixel, relative to the
// smiley's top-left corner, onto a 4-bit {L,T,R,B} edge-band code.
// Ports:
//   pixelX, pixelY     : current scan pixel (unsigned).
//   topLeftX, topLeftY : smiley position (signed).
//   code               : edge-band code, 0 when the pixel is outside the sprite.
//   valid              : pixel lies inside the SMILEY_SIZE x SMILEY_SIZE box.
module smiley_edge_classifier
  import defines::*;
#(
  parameter int unsigned SMILEY_SIZE = SMILEY_SIZE_DEFAULT,
  parameter int unsigned EDGE_MARGIN = EDGE_MARGIN_DEFAULT
) (
  input  logic        [10:0] pixelX,
  input  logic        [10:0] pixelY,
  input  logic signed [10:0] topLeftX,
  input  logic signed [10:0] topLeftY,
  output logic        [3:0]  code,
  output logic               valid
);

  localparam logic signed [11:0] SizeS   = 12'(SMILEY_SIZE);
  localparam logic signed [11:0] MarginS = 12'(EDGE_MARGIN);
  localparam logic signed [11:0] FarS    = 12'(SMILEY_SIZE - EDGE_MARGIN);

  logic signed [11:0] off_x;
  logic signed [11:0] off_y;
  logic        [3:0]  bands;

  // 12-bit signed offsets; wrap-around simply lands outside the valid box.
  assign off_x = $signed({1'b0, pixelX}) - $signed({topLeftX[10], topLeftX});
  assign off_y = $signed({1'b0, pixelY}) - $signed({topLeftY[10], topLeftY});

  always_comb begin
    valid = (off_x >= 12'sd0) && (off_x < SizeS) && (off_y >= 12'sd0) && (off_y < SizeS);
    bands              = '0;
    bands[EDGE_LEFT]   = off_x <  MarginS;
    bands[EDGE_TOP]    = off_y <  MarginS;
    bands[EDGE_RIGHT]  = off_x >= FarS;
    bands[EDGE_BOTTOM] = off_y >= FarS;
    code               = bands & {4{valid}};
  end

endmodule

// File: rtl/smiley_collision_detector.sv
// Per-frame collision detector for the smiley sprite.
// Accumulates, per object, whether the smiley overlapped it during the frame
// and the OR of the edge codes of those overlaps. On startOfFrame the result
// is snapshotted and replayed as a fixed five-cycle burst (FRAME, OBSTACLE,
// SPRING, FLIPPER, BUMPER), one registered pulse per pending object.
// Ports:
//   clk, reset          : clock, synchronous active-high reset.
//   startOfFrame, pause : frame strobe; pause inhibits accumulation only.
//   pixelX/Y, topLeftX/Y: scan pixel and smiley position.
//   smileyDR, *DR       : drawing requests for the current pixel.
//   collisionSmiley*    : one-cycle collision pulses.
//   hitEdgeCode         : {L,T,R,B} of the pulsing object, 0 otherwise.
// Build option: COLLISION_DEBOUNCE_EN suppresses a pulse that repeats the
// object's previously reported edge code.
module smiley_collision_detector
  import defines::*;
#(
  parameter int unsigned SMILEY_SIZE = SMILEY_SIZE_DEFAULT,
  parameter int unsigned EDGE_MARGIN = EDGE_MARGIN_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               pause,
  input  logic        [10:0] pixelX,
  input  logic        [10:0] pixelY,
  input  logic signed [10:0] topLeftX,
  input  logic signed [10:0] topLeftY,
  input  logic               smileyDR,
  input  logic               frameDR,
  input  logic               obstacleDR,
  input  logic               springDR,
  input  logic               flipperDR,
  input  logic               bumperDR,
  output logic               collisionSmileyFrame,
  output logic               collisionSmileyObstacle,
  output logic               collisionSmileySpringPulse,
  output logic               collisionSmileyFlipper,
  output logic               collisionSmileyBumper,
  output logic        [3:0]  hitEdgeCode
);

  logic [3:0]         cls_code;
  logic               cls_valid;
  logic [3:0]         pix_code;
  logic [NUM_OBJ-1:0] obj_dr;
  logic [NUM_OBJ-1:0] hit;

  logic [NUM_OBJ-1:0]       seen_q, seen_d, pend_q, pend_d;
  logic [NUM_OBJ-1:0][3:0]  acc_q, acc_d, pcode_q, pcode_d;

  emit_state_e        state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [NUM_OBJ-1:0] pulse_q, pulse_d;
  logic [3:0]         code_q, code_d;

  logic               emit_sel;
  logic [2:0]         emit_idx;
  logic               emit_pend;
  logic [3:0]         emit_code;
  logic               fire;

`ifdef COLLISION_DEBOUNCE_EN
  logic [NUM_OBJ-1:0]      hist_valid_q, hist_valid_d;
  logic [NUM_OBJ-1:0][3:0] hist_code_q, hist_code_d;
`endif

  smiley_edge_classifier #(
    .SMILEY_SIZE (SMILEY_SIZE),
    .EDGE_MARGIN (EDGE_MARGIN)
  ) u_classifier (
    .pixelX   (pixelX),
    .pixelY   (pixelY),
    .topLeftX (topLeftX),
    .topLeftY (topLeftY),
    .code     (cls_code),
    .valid    (cls_valid)
  );

  assign pix_code = cls_valid ? cls_code : 4'b0000;
  assign obj_dr   = {bumperDR, flipperDR, springDR, obstacleDR, frameDR};
  assign hit      = obj_dr & {NUM_OBJ{smileyDR & ~pause}};

  // Accumulation and snapshot. The startOfFrame pixel belongs to the new frame.
  always_comb begin
    seen_d  = seen_q;
    acc_d   = acc_q;
    pend_d  = pend_q;
    pcode_d = pcode_q;
    if (startOfFrame) begin
      pend_d  = seen_q;
      pcode_d = acc_q;
      seen_d  = '0;
      acc_d   = '0;
    end
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (hit[i]) begin
        seen_d[i] = 1'b1;
        acc_d[i]  = acc_d[i] | pix_code;
      end
    end
  end

  // Emission FSM. Outputs are registered, so the slot loaded on the
  // startOfFrame edge (index 0) is taken straight from the live accumulators;
  // idx_q names the next slot to load while in StEmit.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pulse_d   = '0;
    code_d    = 4'b0000;
    emit_sel  = 1'b0;
    emit_idx  = idx_q;
    emit_pend = 1'b0;
    emit_code = 4'b0000;
    fire      = 1'b0;
`ifdef COLLISION_DEBOUNCE_EN
    hist_valid_d = hist_valid_q;
    hist_code_d  = hist_code_q;
`endif
    if (startOfFrame) begin
      emit_sel  = 1'b1;
      emit_idx  = 3'd0;
      emit_pend = seen_q[0];
      emit_code = acc_q[0];
      state_d   = StEmit;
      idx_d     = 3'd1;
    end else if (state_q == StEmit) begin
      emit_sel  = 1'b1;
      emit_pend = pend_q[idx_q];
      emit_code = pcode_q[idx_q];
      if (idx_q == 3'd4) begin
        state_d = StIdle;
        idx_d   = 3'd0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end

    if (emit_sel) begin
      fire = emit_pend;
`ifdef COLLISION_DEBOUNCE_EN
      // History follows the last reported overlap; a suppressed repeat keeps
      // it alive, a slot with no overlap clears it.
      if (emit_pend) begin
        fire = !(hist_valid_q[emit_idx] && (hist_code_q[emit_idx] == emit_code));
        hist_valid_d[emit_idx] = 1'b1;
        hist_code_d[emit_idx]  = emit_code;
      end else begin
        hist_valid_d[emit_idx] = 1'b0;
      end
`endif
      if (fire) begin
        pulse_d[emit_idx] = 1'b1;
        code_d            = emit_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seen_q  <= '0;
      acc_q   <= '0;
      pend_q  <= '0;
      pcode_q <= '0;
      state_q <= StIdle;
      idx_q   <= 3'd0;
      pulse_q <= '0;
      code_q  <= 4'b0000;
`ifdef COLLISION_DEBOUNCE_EN
      hist_valid_q <= '0;
      hist_code_q  <= '0;
`endif
    end else begin
      seen_q  <= seen_d;
      acc_q   <= acc_d;
      pend_q  <= pend_d;
      pcode_q <= pcode_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      pulse_q <= pulse_d;
      code_q  <= code_d;
`ifdef COLLISION_DEBOUNCE_EN
      hist_valid_q <= hist_valid_d;
      hist_code_q  <= hist_code_d;
`endif
    end
  end

  assign collisionSmileyFrame       = pulse_q[FRAME];
  assign collisionSmileyObstacle    = pulse_q[OBSTACLE];
  assign collisionSmileySpringPulse = pulse_q[SPRING];
  assign collisionSmileyFlipper     = pulse_q[FLIPPER];
  assign collisionSmileyBumper      = pulse_q[BUMPER];
  assign hitEdgeCode                = code_q;

endmodule

// File: tb/tb_smiley_collision_detector.sv
// Self-checking bench for smiley_collision_detector: directed frames followed
// by randomized traffic, every cycle compared against a schedule-based model.
// Honours COLLISION_DEBOUNCE_EN when defined for the build.
module tb_smiley_collision_detector;

  localparam int SIZE   = 32;
  localparam int MARGIN = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset = 1'b1, startOfFrame = 1'b0, pause = 1'b0;
  logic        [10:0] pixelX = '0, pixelY = '0;
  logic signed [10:0] topLeftX = '0, topLeftY = '0;
  logic smileyDR = 1'b0, frameDR = 1'b0, obstacleDR = 1'b0;
  logic springDR = 1'b0, flipperDR = 1'b0, bumperDR = 1'b0;
  logic c_frame, c_obst, c_spring, c_flip, c_bump;
  logic [3:0] hitEdgeCode;

  smiley_collision_detector dut (
    .clk                        (clk),
    .reset                      (reset),
    .startOfFrame               (startOfFrame),
    .pause                      (pause),
    .pixelX                     (pixelX),
    .pixelY                     (pixelY),
    .topLeftX                   (topLeftX),
    .topLeftY                   (topLeftY),
    .smileyDR                   (smileyDR),
    .frameDR                    (frameDR),
    .obstacleDR                 (obstacleDR),
    .springDR                   (springDR),
    .flipperDR                  (flipperDR),
    .bumperDR                   (bumperDR),
    .collisionSmileyFrame       (c_frame),
    .collisionSmileyObstacle    (c_obst),
    .collisionSmileySpringPulse (c_spring),
    .collisionSmileyFlipper     (c_flip),
    .collisionSmileyBumper      (c_bump),
    .hitEdgeCode                (hitEdgeCode)
  );

  // Staged inputs for the next cycle.
  logic               s_rst, s_sof, s_pause, s_smiley;
  logic [4:0]         s_dr;
  logic [10:0]        s_px, s_py;
  logic signed [10:0] s_tx, s_ty;

  // Model: each startOfFrame books five report slots at fixed future cycles.
  typedef struct {
    int         cyc;
    int         obj;
    bit         pend;
    logic [3:0] code;
  } slot_t;
  slot_t      sched[$];
  bit         m_seen[5];
  logic [3:0] m_acc[5];
  bit         h_valid[5];
  logic [3:0] h_code[5];

  int   cyc_n = 0, checks = 0, failures = 0;
  bit   armed = 1'b0;
  logic [4:0] obs_p;
  logic [3:0] obs_c;
  logic [8:0] rec[5];

  function automatic int wrap12(int v);
    logic signed [11:0] t;
    t = v[11:0];
    return int'(t);
  endfunction

  function automatic logic [3:0] ref_code(int px, int py, int tx, int ty);
    int ox, oy;
    ox = wrap12(px - tx);
    oy = wrap12(py - ty);
    if (ox < 0 || ox >= SIZE || oy < 0 || oy >= SIZE) return 4'b0000;
    return {ox < MARGIN, oy < MARGIN, ox >= SIZE - MARGIN, oy >= SIZE - MARGIN};
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed pulses/code=%b required=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [8:0] exp;
    logic [3:0] code;
    slot_t      s;
    bit         fire;
    @(negedge clk);
    exp = '0;
    if (sched.size() > 0 && sched[0].cyc == cyc_n) begin
      s    = sched.pop_front();
      fire = s.pend;
`ifdef COLLISION_DEBOUNCE_EN
      if (s.pend) begin
        if (h_valid[s.obj] && h_code[s.obj] == s.code) fire = 1'b0;
        h_valid[s.obj] = 1'b1;
        h_code[s.obj]  = s.code;
      end else begin
        h_valid[s.obj] = 1'b0;
      end
`endif
      if (fire) begin
        exp[4 + s.obj] = 1'b1;
        exp[3:0]       = s.code;
      end
    end
    obs_p = {c_bump, c_flip, c_spring, c_obst, c_frame};
    obs_c = hitEdgeCode;
    if (armed) begin
      check($sformatf("cycle%0d", cyc_n), {obs_p, obs_c}, exp);
      check($sformatf("onehot%0d", cyc_n), {8'd0, $countones(obs_p) <= 1}, 9'd1);
    end
    reset = s_rst; startOfFrame = s_sof; pause = s_pause; smileyDR = s_smiley;
    {bumperDR, flipperDR, springDR, obstacleDR, frameDR} = s_dr;
    pixelX = s_px; pixelY = s_py; topLeftX = s_tx; topLeftY = s_ty;
    @(posedge clk);
    if (s_rst) begin
      sched.delete();
      for (int i = 0; i < 5; i++) begin
        m_seen[i] = 1'b0; m_acc[i] = '0; h_valid[i] = 1'b0; h_code[i] = '0;
      end
      armed = 1'b1;
    end else begin
      code = ref_code(int'(s_px), int'(s_py), int'(s_tx), int'(s_ty));
      if (s_sof) begin
        sched.delete();
        for (int k = 0; k < 5; k++) begin
          sched.push_back('{cyc: cyc_n + 1 + k, obj: k, pend: m_seen[k], code: m_acc[k]});
          m_seen[k] = 1'b0;
          m_acc[k]  = '0;
        end
      end
      for (int i = 0; i < 5; i++) begin
        if (s_smiley && s_dr[i] && !s_pause) begin
          m_seen[i] = 1'b1;
          m_acc[i]  = m_acc[i] | code;
        end
      end
    end
    cyc_n++;
  endtask

  task automatic stage_idle();
    s_rst = 1'b0; s_sof = 1'b0; s_pause = 1'b0; s_smiley = 1'b0; s_dr = '0;
  endtask

  task automatic overlap(input int x, input int y, input logic [4:0] dr, input bit p);
    stage_idle();
    s_px = 11'(x); s_py = 11'(y); s_smiley = 1'b1; s_dr = dr; s_pause = p;
    tick();
  endtask

  task automatic frame_start();
    stage_idle();
    s_sof = 1'b1;
    tick();
  endtask

  task automatic burst();
    for (int k = 0; k < 5; k++) begin
      stage_idle();
      tick();
      rec[k] = {obs_p, obs_c};
    end
  endtask

  initial begin
    int tx, ty, px, py;
    stage_idle();
    s_px = '0; s_py = '0; s_tx = '0; s_ty = '0;
    s_rst = 1'b1;
    repeat (3) tick();
    stage_idle();
    tick();
    check("reset_outputs", {obs_p, obs_c}, 9'd0);

    // Empty frame: no pulses anywhere in the burst.
    frame_start();
    burst();
    for (int k = 0; k < 5; k++) check($sformatf("empty_slot%0d", k), rec[k], 9'd0);

    // Left-edge frame overlap.
    s_tx = 11'sd100; s_ty = 11'sd200;
    overlap(101, 215, 5'b00001, 1'b0);
    frame_start();
    burst();
    check("frame_left", rec[0], {5'b00001, 4'b1000});
    check("frame_only", rec[1] | rec[2] | rec[3] | rec[4], 9'd0);

    // Spring bottom edge, bumper interior (code 0 still pulses).
    overlap(116, 231, 5'b00100, 1'b0);
    overlap(116, 215, 5'b10000, 1'b0);
    frame_start();
    burst();
    check("spring_bottom", rec[2], {5'b00100, 4'b0001});
    check("bumper_zero", rec[4], {5'b10000, 4'b0000});
    check("no_frame", rec[0], 9'd0);

    // Two obstacle corners merge into one pulse.
    overlap(101, 201, 5'b00010, 1'b0);
    overlap(131, 231, 5'b00010, 1'b0);
    frame_start();
    burst();
    check("obstacle_all", rec[1], {5'b00010, 4'b1111});

    // Paused overlap is not recorded.
    overlap(101, 215, 5'b00001, 1'b1);
    frame_start();
    burst();
    check("pause_frame", rec[0], 9'd0);

    // Re-snapshot two cycles into a burst.
    overlap(101, 215, 5'b00001, 1'b0);
    overlap(116, 215, 5'b10000, 1'b0);
    frame_start();
    stage_idle();
    tick();
    check("resnap_first", {obs_p, obs_c}, {5'b00001, 4'b1000});
    frame_start();
    check("resnap_old_obst", {obs_p, obs_c}, 9'd0);
    burst();
    check("resnap_no_dup", rec[0], 9'd0);
    check("resnap_dropped", rec[2], 9'd0);

    // Repeated flipper code, then a changed code.
    for (int f = 0; f < 3; f++) begin
      overlap(116, 231, 5'b01000, 1'b0);
      frame_start();
      burst();
`ifdef COLLISION_DEBOUNCE_EN
      check($sformatf("flip_rep%0d", f), rec[3], (f == 0) ? {5'b01000, 4'b0001} : 9'd0);
`else
      check($sformatf("flip_rep%0d", f), rec[3], {5'b01000, 4'b0001});
`endif
    end
    overlap(116, 201, 5'b01000, 1'b0);
    overlap(116, 231, 5'b01000, 1'b0);
    frame_start();
    burst();
    check("flip_change", rec[3], {5'b01000, 4'b0101});

    // Randomized traffic against the model.
    tx = 100; ty = 200;
    for (int i = 0; i < 600; i++) begin
      stage_idle();
      if ($urandom_range(0, 15) == 0) begin
        tx = int'($urandom_range(0, 1040)) - 40;
        ty = int'($urandom_range(0, 1040)) - 40;
      end
      if ($urandom_range(0, 9) == 0) begin
        px = int'($urandom_range(0, 2047));
        py = int'($urandom_range(0, 2047));
      end else begin
        px = tx + int'($urandom_range(0, 40)) - 4;
        py = ty + int'($urandom_range(0, 40)) - 4;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
      end
      s_tx = 11'(tx); s_ty = 11'(ty); s_px = 11'(px); s_py = 11'(py);
      s_sof    = ($urandom_range(0, 6) == 0);
      s_pause  = ($urandom_range(0, 5) == 0);
      s_smiley = ($urandom_range(0, 3) != 0);
      s_dr     = 5'($urandom_range(0, 31));
      s_rst    = ($urandom_range(0, 199) == 0);
      tick();
    end
    stage_idle();
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
